vga_text_avl_writer: RTL and testbench
======================================

# vga_text_avl_writer

Avalon-MM master that drives the VGA text-mode display's VRAM and control register from a simple command stream. It accepts character, clear-screen, set-colour and home-cursor commands, tracks an 80x30 cursor, and issues byte-enabled single-word writes to the text display's slave port. It sits between a hardware producer (UART receiver, keyboard decoder, debug logger) and the display's Avalon-MM slave, replacing software character writes.

## Interface
- COLS, 80, characters per row
- ROWS, 30, character rows
- CTRL_ADDR, 600, word address of the display control register
- CLK  in  1  system clock, 50 MHz, shared with the display
- RESET_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  block can accept a command
- CMD_OP  in  2  00 char, 01 clear, 10 set colour, 11 home
- CMD_DATA  in  24  char: [7] inverse, [6:0] glyph code; colour: [23:12] FGD R/G/B (4 bits each, R in [23:20]), [11:0] BKG R/G/B
- AVM_ADDRESS  out  10  word address
- AVM_WRITE  out  1  write request
- AVM_CHIPSELECT  out  1  equals AVM_WRITE
- AVM_BYTEENABLE  out  4  byte lanes
- AVM_WRITEDATA  out  32  write data
- AVM_WAITREQUEST  in  1  slave stall
- CURSOR_X  out  7  current column, 0..79
- CURSOR_Y  out  5  current row, 0..29
- BUSY  out  1  state != IDLE

## Operation
- FSM states: IDLE, WR_CHAR, WR_CTRL, CLEAR.
- CMD_READY = (state == IDLE). A command is accepted on a cycle with CMD_VALID && CMD_READY.
- Char op, CMD_DATA[6:0] == 0x0A: no bus write; X <= 0, Y <= Y+1 (29 wraps to 0); stay IDLE.
- Char op, any other code: index = Y*80 + X (12 bits, max 2399); address = index[11:2]; byteenable = 4'b0001 << index[1:0]; writedata = CMD_DATA[7:0] replicated into all four lanes. Go to WR_CHAR. When the write completes, advance the cursor: X+1; if X == 79 then X <= 0, Y+1; Y == 29 wraps to 0 (no scroll).
- Set colour: address = CTRL_ADDR, byteenable 4'b1111, writedata = {7'b0, CMD_DATA[23:0], 1'b0}. Go to WR_CTRL. Cursor is unchanged.
- Clear: write 32'h0, byteenable 4'b1111, to word addresses 0..599 in ascending order using a 10-bit word counter. After the write to word 599 completes, cursor <= (0,0).
- Home: cursor <= (0,0) in the accept cycle; no bus write; stay IDLE.
- Avalon rule: a write completes on a cycle with AVM_WRITE=1 and AVM_WAITREQUEST=0. While WAITREQUEST=1, address, data, byteenable and write stay stable.

## Timing
- All AVM_* outputs, CURSOR_* and BUSY are registered. CMD_READY is combinational from state.
- Reset values: AVM_WRITE=0, AVM_CHIPSELECT=0, AVM_ADDRESS=0, AVM_BYTEENABLE=0, AVM_WRITEDATA=0, cursor (0,0), BUSY=0, state IDLE (CMD_READY=1).
- Accept in cycle N drives AVM_WRITE=1 in cycle N+1.
- With zero wait states:
  - char and colour writes: AVM_WRITE high for exactly 1 cycle, IDLE in N+2, sustained throughput 1 command per 2 cycles;
  - clear: AVM_WRITE high for 600 consecutive cycles with the address incrementing every cycle, IDLE the cycle after word 599.
- Each WAITREQUEST cycle extends the current write by one cycle.
- Cursor update is visible the cycle after write completion, or the cycle after accept for newline and home.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). A partial clear is abandoned and not resumed.
- CMD_DATA bits unused by an op are ignored. CMD_DATA[23:8] is ignored for char ops.

## Structure
- Package vga_text_pkg:
  - COLS, ROWS, VRAM_WORDS=600, CTRL_ADDR=600;
  - enum cmd_op_e {OP_CHAR, OP_CLEAR, OP_COLOR, OP_HOME};
  - enum state_e;
  - helper function for the control-word packing.
- Sub-module text_cursor holds the X/Y counters with inc, newline and home inputs and both wrap rules. The FSM and Avalon driver stay in the top module.

## Test plan
- Reset, then char 0x41 at (0,0), no wait states -> one write: addr 0, BE 0001, data 0x41414141; cursor becomes (1,0); IDLE in 2 cycles.
- Char 0xC8 sent with cursor at (5,2) -> index 165: addr 41, BE 0010, data 0xC8C8C8C8; cursor becomes (6,2).
- Cursor at (79,29), char 0x20 -> addr 599, BE 1000; cursor wraps to (0,0). Then newline at (3,29) -> cursor (0,0) with no bus activity.
- Set colour CMD_DATA=0xF00_00F -> addr 600, BE 1111, data 0x01E0001E.
- Clear with WAITREQUEST held high for 2 cycles on every 100th write -> exactly 600 writes to addresses 0..599, all data 0; signals stable during stalls; cursor (0,0) at the end; CMD_READY=0 throughout.
- Drop RESET_N at clear word 300 -> AVM_WRITE=0 the same cycle. After release, CMD_READY=1, cursor (0,0), and the next char writes to addr 0.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants, command/state encodings and control-word packing for the
// VGA text-mode Avalon-MM writer.
package vga_text_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 30;
  localparam int VRAM_WORDS = 600;
  localparam int CTRL_ADDR  = 600;

  typedef enum logic [1:0] {
    OP_CHAR  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_COLOR = 2'b10,
    OP_HOME  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_CHAR,
    S_WR_CTRL,
    S_CLEAR
  } state_e;

  // Control register layout: foreground RGB in [24:13], background RGB in [12:1].
  function automatic logic [31:0] pack_ctrl(input logic [23:0] i_colour);
    return {7'b0, i_colour, 1'b0};
  endfunction

endpackage

// File: rtl/text_cursor.sv
// 80x30 text cursor: advance, newline and home, with column and row wrap
// (row wraps to the top; there is no scrolling).
module text_cursor #(
  parameter int COLS = vga_text_pkg::COLS,
  parameter int ROWS = vga_text_pkg::ROWS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_newline,
  input  logic       i_home,
  output logic [6:0] o_x,
  output logic [4:0] o_y
);

  logic [6:0] r_x;
  logic [4:0] r_y;
  logic [4:0] w_y_next;

  assign w_y_next = (r_y == 5'(ROWS - 1)) ? '0 : r_y + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_home) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_newline) begin
      r_x <= '0;
      r_y <= w_y_next;
    end else if (i_inc) begin
      if (r_x == 7'(COLS - 1)) begin
        r_x <= '0;
        r_y <= w_y_next;
      end else begin
        r_x <= r_x + 7'd1;
      end
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/vga_text_avl_writer.sv
// Command-stream front end for the VGA text display: turns char/clear/colour/
// home commands into byte-enabled single-word Avalon-MM writes.
module vga_text_avl_writer #(
  parameter int COLS      = vga_text_pkg::COLS,
  parameter int ROWS      = vga_text_pkg::ROWS,
  parameter int CTRL_ADDR = vga_text_pkg::CTRL_ADDR
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [23:0] CMD_DATA,
  output logic [9:0]  AVM_ADDRESS,
  output logic        AVM_WRITE,
  output logic        AVM_CHIPSELECT,
  output logic [3:0]  AVM_BYTEENABLE,
  output logic [31:0] AVM_WRITEDATA,
  input  logic        AVM_WAITREQUEST,
  output logic [6:0]  CURSOR_X,
  output logic [4:0]  CURSOR_Y,
  output logic        BUSY
);
  import vga_text_pkg::*;

  state_e      r_state, w_state_nxt;
  logic        r_write, w_write_nxt;
  logic [9:0]  r_addr,  w_addr_nxt;
  logic [3:0]  r_be,    w_be_nxt;
  logic [31:0] r_data,  w_data_nxt;

  cmd_op_e     w_op;
  logic        w_done;
  logic        w_inc, w_newline, w_home;
  logic [6:0]  w_x;
  logic [4:0]  w_y;
  logic [11:0] w_index;

  assign w_op    = cmd_op_e'(CMD_OP);
  assign w_done  = r_write && !AVM_WAITREQUEST;
  assign w_index = 12'(w_y) * 12'(COLS) + 12'(w_x);

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .i_inc     (w_inc),
    .i_newline (w_newline),
    .i_home    (w_home),
    .o_x       (w_x),
    .o_y       (w_y)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_write <= w_write_nxt;
      r_addr  <= w_addr_nxt;
      r_be    <= w_be_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Bus fields hold their value unless explicitly changed, so a stalled
  // write stays stable without any extra logic.
  always_comb begin
    w_state_nxt = r_state;
    w_write_nxt = r_write;
    w_addr_nxt  = r_addr;
    w_be_nxt    = r_be;
    w_data_nxt  = r_data;
    w_inc       = 1'b0;
    w_newline   = 1'b0;
    w_home      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (CMD_VALID) begin
          case (w_op)
            OP_CHAR: begin
              if (CMD_DATA[6:0] == 7'h0A) begin
                w_newline = 1'b1;
              end else begin
                w_addr_nxt  = w_index[11:2];
                w_be_nxt    = 4'b0001 << w_index[1:0];
                w_data_nxt  = {4{CMD_DATA[7:0]}};
                w_write_nxt = 1'b1;
                w_state_nxt = S_WR_CHAR;
              end
            end
            OP_CLEAR: begin
              w_addr_nxt  = '0;
              w_be_nxt    = '1;
              w_data_nxt  = '0;
              w_write_nxt = 1'b1;
              w_state_nxt = S_CLEAR;
            end
            OP_COLOR: begin
              w_addr_nxt  = 10'(CTRL_ADDR);
              w_be_nxt    = '1;
              w_data_nxt  = pack_ctrl(CMD_DATA);
              w_write_nxt = 1'b1;
              w_state_nxt = S_WR_CTRL;
            end
            OP_HOME: begin
              w_home = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_WR_CHAR: begin
        if (w_done) begin
          w_write_nxt = 1'b0;
          w_inc       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_WR_CTRL: begin
        if (w_done) begin
          w_write_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      // The address register doubles as the clear word counter.
      S_CLEAR: begin
        if (w_done) begin
          if (r_addr == 10'(VRAM_WORDS - 1)) begin
            w_write_nxt = 1'b0;
            w_home      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_addr_nxt = r_addr + 10'd1;
          end
        end
      end

      default: begin
        w_write_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign CMD_READY      = (r_state == S_IDLE);
  assign BUSY           = (r_state != S_IDLE);
  assign AVM_WRITE      = r_write;
  assign AVM_CHIPSELECT = r_write;
  assign AVM_ADDRESS    = r_addr;
  assign AVM_BYTEENABLE = r_be;
  assign AVM_WRITEDATA  = r_data;
  assign CURSOR_X       = w_x;
  assign CURSOR_Y       = w_y;

endmodule

// File: tb/tb_vga_text_avl_writer.sv
// Randomized bench for vga_text_avl_writer against a cursor/VRAM-write model.
module tb_vga_text_avl_writer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_OP = 2'b00;
  logic [23:0] CMD_DATA = '0;
  logic [9:0]  AVM_ADDRESS;
  logic        AVM_WRITE;
  logic        AVM_CHIPSELECT;
  logic [3:0]  AVM_BYTEENABLE;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic [6:0]  CURSOR_X;
  logic [4:0]  CURSOR_Y;
  logic        BUSY;

  always #10 CLK = ~CLK;

  vga_text_avl_writer #(
    .COLS      (80),
    .ROWS      (30),
    .CTRL_ADDR (600)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .CMD_VALID       (CMD_VALID),
    .CMD_READY       (CMD_READY),
    .CMD_OP          (CMD_OP),
    .CMD_DATA        (CMD_DATA),
    .AVM_ADDRESS     (AVM_ADDRESS),
    .AVM_WRITE       (AVM_WRITE),
    .AVM_CHIPSELECT  (AVM_CHIPSELECT),
    .AVM_BYTEENABLE  (AVM_BYTEENABLE),
    .AVM_WRITEDATA   (AVM_WRITEDATA),
    .AVM_WAITREQUEST (AVM_WAITREQUEST),
    .CURSOR_X        (CURSOR_X),
    .CURSOR_Y        (CURSOR_Y),
    .BUSY            (BUSY)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          mx = 0;
  int          my = 0;
  int          wr_seen = 0;
  int          wr_hi_cyc = 0;
  int          stall_mode = 0;
  int          stall_left = 0;
  int          stalled_for = -1;
  logic        prev_stall = 1'b0;
  logic [46:0] saved = '0;
  logic [9:0]  last_addr = '0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_data = '0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: what a command must produce on the bus and on the cursor.
  task automatic model_apply(input logic [1:0] op, input logic [23:0] d);
    wr_t w;
    int  idx;
    case (op)
      2'b00: begin
        if (d[6:0] == 7'h0A) begin
          mx = 0;
          my = (my + 1) % 30;
        end else begin
          idx    = my * 80 + mx;
          w.addr = 10'(idx / 4);
          w.be   = 4'(1 << (idx % 4));
          w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
          exp_q.push_back(w);
          mx++;
          if (mx == 80) begin
            mx = 0;
            my = (my + 1) % 30;
          end
        end
      end
      2'b01: begin
        for (int a = 0; a < 600; a++) begin
          w.addr = 10'(a);
          w.be   = 4'hF;
          w.data = 32'h0;
          exp_q.push_back(w);
        end
        mx = 0;
        my = 0;
      end
      2'b10: begin
        w.addr = 10'd600;
        w.be   = 4'hF;
        w.data = {7'b0, d, 1'b0};
        exp_q.push_back(w);
      end
      default: begin
        mx = 0;
        my = 0;
      end
    endcase
  endtask

  // Bus monitor and slave: drives WAITREQUEST for the coming edge and scores writes.
  always @(negedge CLK) begin
    if (RESET_N && prev_stall)
      chk_eq("stall_stable",
             64'({AVM_WRITE, AVM_ADDRESS, AVM_BYTEENABLE, AVM_WRITEDATA}), 64'(saved));
    prev_stall = 1'b0;
    if (RESET_N && AVM_WRITE) begin
      wr_hi_cyc++;
      case (stall_mode)
        1: AVM_WAITREQUEST = ($urandom_range(0, 3) == 0);
        2: begin
          if ((wr_seen % 100) == 99 && stalled_for != wr_seen) begin
            stall_left  = 2;
            stalled_for = wr_seen;
          end
          if (stall_left > 0) begin
            AVM_WAITREQUEST = 1'b1;
            stall_left--;
          end else begin
            AVM_WAITREQUEST = 1'b0;
          end
        end
        default: AVM_WAITREQUEST = 1'b0;
      endcase
      if (AVM_WAITREQUEST) begin
        prev_stall = 1'b1;
        saved      = {AVM_WRITE, AVM_ADDRESS, AVM_BYTEENABLE, AVM_WRITEDATA};
      end else begin
        chk_eq("chipselect", 64'(AVM_CHIPSELECT), 64'(AVM_WRITE));
        chk_eq("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk_eq("write_fields", 64'({AVM_ADDRESS, AVM_BYTEENABLE, AVM_WRITEDATA}),
                 64'({e.addr, e.be, e.data}));
        end
        wr_seen++;
        last_addr = AVM_ADDRESS;
        last_be   = AVM_BYTEENABLE;
        last_data = AVM_WRITEDATA;
      end
    end else begin
      AVM_WAITREQUEST = 1'b0;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [23:0] d);
    int n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) begin
      chk_eq("ready_timeout", 64'd0, 64'd1);
      return;
    end
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = d;
    model_apply(op, d);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_DATA  = 24'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((BUSY || !CMD_READY) && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20000) chk_eq("idle_timeout", 64'd0, 64'd1);
    chk_eq("cursor_x", 64'(CURSOR_X), 64'(mx));
    chk_eq("cursor_y", 64'(CURSOR_Y), 64'(my));
    chk_eq("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [23:0] rand_glyph();
    logic [23:0] d;
    d = 24'($urandom);
    d[6:0] = 7'($urandom_range(32'h20, 32'h7E));
    return d;
  endfunction

  initial begin
    int          n;
    int          n0;
    int          clears;
    int          r;
    logic [23:0] d;

    repeat (3) @(negedge CLK);
    chk_eq("rst_write_in_reset", 64'(AVM_WRITE), 64'd0);
    #5 RESET_N = 1'b1;
    @(negedge CLK);
    chk_eq("rst_bus", 64'({AVM_WRITE, AVM_CHIPSELECT, AVM_ADDRESS, AVM_BYTEENABLE, AVM_WRITEDATA}), 64'd0);
    chk_eq("rst_cursor", 64'({CURSOR_X, CURSOR_Y}), 64'd0);
    chk_eq("rst_busy", 64'(BUSY), 64'd0);
    chk_eq("rst_ready", 64'(CMD_READY), 64'd1);

    // First char, zero wait states: write in N+1, idle in N+2.
    send_cmd(2'b00, 24'h000041);
    @(negedge CLK);
    chk_eq("t1_write_n1", 64'({AVM_WRITE, BUSY, CMD_READY}), 64'b110);
    @(negedge CLK);
    chk_eq("t1_idle_n2", 64'({AVM_WRITE, BUSY, CMD_READY}), 64'b001);
    chk_eq("t1_cursor", 64'({CURSOR_X, CURSOR_Y}), 64'({7'd1, 5'd0}));
    chk_eq("t1_bus", 64'({last_addr, last_be, last_data}), 64'({10'd0, 4'b0001, 32'h41414141}));

    // Cursor to (5,2), then glyph 0xC8 with junk in the ignored upper bits.
    send_cmd(2'b11, 24'($urandom));
    send_cmd(2'b00, 24'h00000A);
    send_cmd(2'b00, 24'hABCD8A);
    for (int i = 0; i < 5; i++) send_cmd(2'b00, rand_glyph());
    wait_idle();
    send_cmd(2'b00, {16'($urandom), 8'hC8});
    wait_idle();
    chk_eq("t2_bus", 64'({last_addr, last_be, last_data}), 64'({10'd41, 4'b0010, 32'hC8C8C8C8}));
    chk_eq("t2_cursor", 64'({CURSOR_X, CURSOR_Y}), 64'({7'd6, 5'd2}));

    // Last cell (79,29) and wrap to (0,0).
    send_cmd(2'b11, 24'd0);
    for (int i = 0; i < 29; i++) send_cmd(2'b00, 24'h00000A);
    for (int i = 0; i < 79; i++) send_cmd(2'b00, rand_glyph());
    wait_idle();
    send_cmd(2'b00, 24'h000020);
    wait_idle();
    chk_eq("t3_bus", 64'({last_addr, last_be, last_data}), 64'({10'd599, 4'b1000, 32'h20202020}));
    chk_eq("t3_wrap", 64'({CURSOR_X, CURSOR_Y}), 64'd0);

    // Newline on the last row wraps to the top with no bus traffic.
    for (int i = 0; i < 29; i++) send_cmd(2'b00, 24'h00000A);
    for (int i = 0; i < 3; i++) send_cmd(2'b00, rand_glyph());
    wait_idle();
    n0 = wr_seen;
    send_cmd(2'b00, 24'h00008A);
    wait_idle();
    chk_eq("t3_nl_nowrite", 64'(wr_seen), 64'(n0));
    chk_eq("t3_nl_cursor", 64'({CURSOR_X, CURSOR_Y}), 64'd0);

    send_cmd(2'b10, 24'hF0000F);
    wait_idle();
    chk_eq("t4_colour", 64'({last_addr, last_be, last_data}), 64'({10'd600, 4'hF, 32'h01E0001E}));

    // Clear with two stall cycles on every 100th write.
    send_cmd(2'b00, rand_glyph());
    send_cmd(2'b00, rand_glyph());
    wait_idle();
    wr_seen     = 0;
    wr_hi_cyc   = 0;
    stall_left  = 0;
    stalled_for = -1;
    stall_mode  = 2;
    send_cmd(2'b01, 24'($urandom));
    n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 2000) begin
      n++;
      @(negedge CLK);
    end
    chk_eq("t5_ready_low_cycles", 64'(n), 64'd612);
    chk_eq("t5_write_cycles", 64'(wr_hi_cyc), 64'd612);
    chk_eq("t5_write_count", 64'(wr_seen), 64'd600);
    chk_eq("t5_last_addr", 64'(last_addr), 64'd599);
    wait_idle();
    stall_mode = 0;

    // Reset in the middle of a clear.
    send_cmd(2'b00, rand_glyph());
    wait_idle();
    send_cmd(2'b01, 24'd0);
    n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (!(AVM_WRITE && AVM_ADDRESS == 10'd300) && n < 2000);
    chk_eq("t6_reached_300", 64'(AVM_ADDRESS), 64'd300);
    #2 RESET_N = 1'b0;
    #1;
    chk_eq("t6_async_bus", 64'({AVM_WRITE, AVM_CHIPSELECT, AVM_ADDRESS, AVM_BYTEENABLE, AVM_WRITEDATA}), 64'd0);
    chk_eq("t6_async_ctl", 64'({CMD_READY, BUSY, CURSOR_X, CURSOR_Y}), 64'({1'b1, 1'b0, 12'd0}));
    exp_q.delete();
    mx = 0;
    my = 0;
    #5 RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk_eq("t6_no_resume", 64'({AVM_WRITE, CMD_READY}), 64'b01);
    send_cmd(2'b00, 24'h00005A);
    wait_idle();
    chk_eq("t6_post_rst", 64'({last_addr, last_be}), 64'({10'd0, 4'b0001}));

    // Random command mix with random wait states.
    stall_mode = 1;
    clears = 0;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      d = 24'($urandom);
      if (r < 70) begin
        if ($urandom_range(0, 9) == 0) d[6:0] = 7'h0A;
        send_cmd(2'b00, d);
      end else if (r < 85) begin
        send_cmd(2'b10, d);
      end else if (r < 95 || clears >= 3) begin
        send_cmd(2'b11, d);
      end else begin
        clears++;
        send_cmd(2'b01, d);
      end
      if ((i % 25) == 24) wait_idle();
    end
    wait_idle();
    stall_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
